// File: rtl/motor_pkg.sv
// Shared definitions for the motor speed path: speed level encoding and legality check.
// Used by the button-driven speed FSM and by the PWM generator.
package motor_pkg;

  localparam int LEVEL_W    = 3;
  localparam int NUM_LEVELS = 5;

  typedef enum logic [LEVEL_W-1:0] {
    PWM0 = 3'b000,
    PWM1 = 3'b001,
    PWM2 = 3'b010,
    PWM3 = 3'b011,
    PWM4 = 3'b100
  } pwm_level_e;

  // Encodings 5..7 never come from the FSM; they are treated as level 0.
  function automatic logic level_is_legal(input logic [LEVEL_W-1:0] lvl);
    return lvl < LEVEL_W'(NUM_LEVELS);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Clock prescaler: asserts o_tick for one clock out of every PRESCALE clocks.
// The first tick after reset lands in the PRESCALE-th clock.
module pwm_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // With PRESCALE == 1 the counter stays at 0 == LAST, so every clock ticks.
  assign o_tick = (pre_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pre_cnt <= '0;
    end else if (o_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/motor_pwm_gen.sv
// Turns the FSM speed level into a glitch-free PWM waveform whose duty slews
// toward the level's target by at most RAMP_STEP ticks per period.
module motor_pwm_gen
  import motor_pkg::*;
#(
  parameter int  PERIOD    = 100,
  parameter int  PRESCALE  = 4,
  parameter int  RAMP_STEP = 5,
  localparam int CW        = $clog2(PERIOD + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [LEVEL_W-1:0] i_pwm_state,
  output logic               o_pwm,
  output logic [CW-1:0]      o_duty,
  output logic               o_period_end,
  output logic               o_ramping
);

  localparam int XW = CW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [XW-1:0] STEP_X   = XW'(RAMP_STEP);

  logic [LEVEL_W-1:0] state_q;
  logic [CW-1:0]      target;
  logic               tick;
  logic               period_end;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_next;
  logic [CW-1:0]      duty;
  logic [CW-1:0]      duty_step;
  logic [CW-1:0]      duty_next;
  logic [XW-1:0]      duty_x;
  logic [XW-1:0]      target_x;
  logic [XW-1:0]      up_x;
  logic [XW-1:0]      dn_x;
  logic               pwm;

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= '0;
    end else begin
      state_q <= i_pwm_state;
    end
  end

  always_comb begin
    target = '0;
    if (level_is_legal(state_q)) begin
      target = CW'((int'(state_q) * PERIOD) / 4);
    end
  end

  assign period_end = tick && (cnt == CNT_LAST);

  always_comb begin
    cnt_next = cnt;
    if (tick) begin
      cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // One extra bit keeps duty +/- RAMP_STEP from wrapping before the clamp.
  assign duty_x   = {1'b0, duty};
  assign target_x = {1'b0, target};
  assign up_x     = duty_x + STEP_X;
  assign dn_x     = duty_x - STEP_X;

  always_comb begin
    duty_step = duty;
    if (duty_x < target_x) begin
      duty_step = (up_x >= target_x) ? target : up_x[CW-1:0];
    end else if (duty_x > target_x) begin
      duty_step = (duty_x <= target_x + STEP_X) ? target : dn_x[CW-1:0];
    end
  end

  assign duty_next = period_end ? duty_step : duty;

  // Comparing the next-state values makes o_pwm track (cnt < duty) with no lag,
  // so a full-scale duty stays high straight through the wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt  <= '0;
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      duty <= duty_next;
      pwm  <= (cnt_next < duty_next);
    end
  end

  assign o_pwm        = pwm;
  assign o_duty       = duty;
  assign o_period_end = period_end;
  assign o_ramping    = (duty != target);

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Directed bench for motor_pwm_gen with PERIOD=8, PRESCALE=2, RAMP_STEP=2 (16-clock periods).
// Each table row applies a level mid-period and checks that period's duty, high time and framing.
module tb_motor_pwm_gen;

  localparam int PERIOD    = 8;
  localparam int PRESCALE  = 2;
  localparam int RAMP_STEP = 2;
  localparam int CW        = 4;
  localparam int CLKS      = PERIOD * PRESCALE;
  localparam int NVEC      = 31;

  typedef struct {
    logic [2:0] level;
    int         at;
    int         duty;
    int         high;
    logic       ramp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    pwm_state = 3'd4;
  logic          pwm;
  logic [CW-1:0] duty;
  logic          period_end;
  logic          ramping;

  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  motor_pwm_gen #(
    .PERIOD   (PERIOD),
    .PRESCALE (PRESCALE),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_pwm_state (pwm_state),
    .o_pwm       (pwm),
    .o_duty      (duty),
    .o_period_end(period_end),
    .o_ramping   (ramping)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s = %0d", name, actual);
    end
  endtask

  // Released at a falling edge: the first period spans 16 rising edges, so its
  // last clock (period_end high) is seen at the 15th falling-edge sample.
  task automatic wait_first_period_end(input string name);
    int k;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (period_end === 1'b1) break;
    end
    check(name, k, CLKS - 1);
  endtask

  // Entered aligned on a period_end sample; leaves aligned on the next one.
  task automatic run_row(input int r);
    int   d;
    int   hi;
    int   pe_ok;
    logic rmp;
    d     = -1;
    hi    = 0;
    pe_ok = 1;
    rmp   = 1'bx;
    for (int i = 0; i < CLKS; i++) begin
      @(negedge clk);
      if (i == vecs[r].at) pwm_state = vecs[r].level;
      if (i == 0) d = int'(duty);
      if (pwm === 1'b1) hi++;
      if ((period_end === 1'b1) != (i == CLKS - 1)) pe_ok = 0;
      if (i == CLKS - 1) rmp = ramping;
    end
    check($sformatf("row%0d_lvl%0d_duty", r, vecs[r].level), d, vecs[r].duty);
    check($sformatf("row%0d_lvl%0d_high", r, vecs[r].level), hi, vecs[r].high);
    check($sformatf("row%0d_lvl%0d_ramping", r, vecs[r].level), {31'd0, rmp}, {31'd0, vecs[r].ramp});
    check($sformatf("row%0d_period_frame", r), pe_ok, 1);
  endtask

  initial begin
    // Ramp up to level 2 (target 4).
    vecs[0]  = '{3'd2, 4, 0, 0,  1'b1};
    vecs[1]  = '{3'd2, 4, 2, 4,  1'b1};
    vecs[2]  = '{3'd2, 4, 4, 8,  1'b0};
    // Level 4: full scale, then held high for three periods.
    vecs[3]  = '{3'd4, 4, 4, 8,  1'b1};
    vecs[4]  = '{3'd4, 4, 6, 12, 1'b1};
    vecs[5]  = '{3'd4, 4, 8, 16, 1'b0};
    vecs[6]  = '{3'd4, 4, 8, 16, 1'b0};
    vecs[7]  = '{3'd4, 4, 8, 16, 1'b0};
    // Level 0: 8 -> 6 -> 4 -> 2 -> 0.
    vecs[8]  = '{3'd0, 4, 8, 16, 1'b1};
    vecs[9]  = '{3'd0, 4, 6, 12, 1'b1};
    vecs[10] = '{3'd0, 4, 4, 8,  1'b1};
    vecs[11] = '{3'd0, 4, 2, 4,  1'b1};
    vecs[12] = '{3'd0, 4, 0, 0,  1'b0};
    // Settle at level 3 (target 6).
    vecs[13] = '{3'd3, 4, 0, 0,  1'b1};
    vecs[14] = '{3'd3, 4, 2, 4,  1'b1};
    vecs[15] = '{3'd3, 4, 4, 8,  1'b1};
    vecs[16] = '{3'd3, 4, 6, 12, 1'b0};
    // Switch to level 1 at cnt=3 (sample 6): running period keeps duty 6.
    vecs[17] = '{3'd1, 6, 6, 12, 1'b1};
    vecs[18] = '{3'd1, 4, 4, 8,  1'b1};
    vecs[19] = '{3'd1, 4, 2, 4,  1'b0};
    // Back to duty 4, then illegal level 7 drives target to 0.
    vecs[20] = '{3'd2, 4, 2, 4,  1'b1};
    vecs[21] = '{3'd7, 4, 4, 8,  1'b1};
    vecs[22] = '{3'd7, 4, 2, 4,  1'b1};
    vecs[23] = '{3'd7, 4, 0, 0,  1'b0};
    vecs[24] = '{3'd5, 4, 0, 0,  1'b0};
    vecs[25] = '{3'd6, 4, 0, 0,  1'b0};
    // Start a 0 -> 8 ramp, interrupted by reset in the following period.
    vecs[26] = '{3'd4, 4, 0, 0,  1'b1};
    vecs[27] = '{3'd4, 4, 2, 4,  1'b1};
    vecs[28] = '{3'd4, 4, 4, 8,  1'b1};
    // After the reset the ramp restarts from 0 (first period unmeasured at duty 0).
    vecs[29] = '{3'd4, 4, 2, 4,  1'b1};
    vecs[30] = '{3'd4, 4, 4, 8,  1'b1};

    repeat (5) @(negedge clk);
    check("reset_pwm", {31'd0, pwm}, 0);
    check("reset_duty", {28'd0, duty}, 0);
    check("reset_period_end", {31'd0, period_end}, 0);
    check("reset_ramping", {31'd0, ramping}, 0);
    pwm_state = 3'd0;
    rst       = 1'b0;
    wait_first_period_end("first_period_end");

    for (int r = 0; r <= 28; r++) run_row(r);

    // Duty is now 6; sample 10 of the period is cnt=5, where o_pwm is high.
    for (int i = 0; i <= 10; i++) @(negedge clk);
    check("midramp_duty_before", {28'd0, duty}, 6);
    check("midramp_pwm_before", {31'd0, pwm}, 1);
    #3 rst = 1'b1;
    #1;
    check("async_reset_pwm", {31'd0, pwm}, 0);
    check("async_reset_duty", {28'd0, duty}, 0);
    check("async_reset_ramping", {31'd0, ramping}, 0);
    check("async_reset_period_end", {31'd0, period_end}, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    wait_first_period_end("post_reset_period_end");
    for (int r = 29; r < NVEC; r++) run_row(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
